matrix_c_row_streamer: RTL and testbench

- Sequential successor to the combinational row-select mux for the matrix C output path.
- Captures all N_SIZE result rows from the systolic array in one cycle.
- Streams them one row per transfer on a valid/ready interface toward the matrix C output port.
- Supports a runtime active-row count for smaller matrices, and back-to-back loads.

---
 rtl/matrix_c_row_streamer_if.sv | 21 ++
 rtl/matrix_c_row_streamer.sv | 115 +++++++++++
 tb/tb_matrix_c_row_streamer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/matrix_c_row_streamer_if.sv
// Row stream from the matrix C streamer toward the output port.
// Master drives the row, slave returns out_ready.
interface matrix_c_row_streamer_if #(
    parameter int DATAWIDTH = 160,
    parameter int IDXW      = 3
);
    logic [DATAWIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [IDXW-1:0]      out_row_idx;
    logic                 out_last;

    modport master (
        output out_data, out_valid, out_row_idx, out_last,
        input  out_ready
    );
    modport slave (
        input  out_data, out_valid, out_row_idx, out_last,
        output out_ready
    );
endinterface

// File: rtl/matrix_c_row_streamer.sv
// Captures N_SIZE rows of matrix C in one cycle and streams one row per transfer.
// Define MATRIX_C_ROW_STREAMER_REVERSE_EN to add the descending-order reverse input.
module matrix_c_row_streamer #(
    parameter int DATAWIDTH = 160,
    parameter int N_SIZE    = 5,
    localparam int IDXW = (N_SIZE > 1) ? $clog2(N_SIZE) : 1,
    localparam int RW   = $clog2(N_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [DATAWIDTH-1:0] in [N_SIZE],
    input  logic [RW-1:0]        active_rows,
`ifdef MATRIX_C_ROW_STREAMER_REVERSE_EN
    input  logic                 reverse,
`endif
    matrix_c_row_streamer_if.master o,
    output logic                 busy,
    output logic                 done,
    output logic                 load_err
);
    typedef enum logic {IDLE, STREAM} state_e;

    state_e               state_q, state_d;
    logic [DATAWIDTH-1:0] buf_q [N_SIZE];
    logic [DATAWIDTH-1:0] buf_d [N_SIZE];
    logic [IDXW-1:0]      cnt_q, cnt_d;
    logic [RW-1:0]        eff_q, eff_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic [RW-1:0]   eff_in, eff_m1;
    logic [IDXW-1:0] first_idx, step_idx;
    logic            at_end, valid, last, fire, fin, accept;

    // Out-of-range counts collapse to a full matrix.
    assign eff_in = (active_rows == '0 || active_rows > RW'(N_SIZE))
                  ? RW'(N_SIZE) : active_rows;
    assign eff_m1 = eff_q - RW'(1);

`ifdef MATRIX_C_ROW_STREAMER_REVERSE_EN
    logic rev_q, rev_d;
    assign first_idx = reverse ? IDXW'(eff_in - RW'(1)) : '0;
    assign step_idx  = rev_q ? cnt_q - IDXW'(1) : cnt_q + IDXW'(1);
    assign at_end    = rev_q ? (cnt_q == '0) : (RW'(cnt_q) == eff_m1);
`else
    assign first_idx = '0;
    assign step_idx  = cnt_q + IDXW'(1);
    assign at_end    = (RW'(cnt_q) == eff_m1);
`endif

    assign valid  = (state_q == STREAM);
    assign last   = valid && at_end;
    assign fire   = valid && o.out_ready;
    assign fin    = fire && last;
    assign accept = load && (!valid || fin);

    assign o.out_valid   = valid;
    assign o.out_data    = valid ? buf_q[cnt_q] : '0;
    assign o.out_row_idx = valid ? cnt_q : '0;
    assign o.out_last    = last;
    assign busy          = valid;
    assign done          = done_q;
    assign load_err      = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        eff_d   = eff_q;
        buf_d   = buf_q;
        done_d  = fin;
        err_d   = load && valid && !fin;
`ifdef MATRIX_C_ROW_STREAMER_REVERSE_EN
        rev_d   = rev_q;
`endif
        // A load on the final handshake restarts with no bubble.
        if (accept) begin
            buf_d   = in;
            eff_d   = eff_in;
            cnt_d   = first_idx;
            state_d = STREAM;
`ifdef MATRIX_C_ROW_STREAMER_REVERSE_EN
            rev_d   = reverse;
`endif
        end else if (fin) begin
            state_d = IDLE;
        end else if (fire) begin
            cnt_d = step_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            eff_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < N_SIZE; i++) buf_q[i] <= '0;
`ifdef MATRIX_C_ROW_STREAMER_REVERSE_EN
            rev_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            eff_q   <= eff_d;
            done_q  <= done_d;
            err_q   <= err_d;
            buf_q   <= buf_d;
`ifdef MATRIX_C_ROW_STREAMER_REVERSE_EN
            rev_q   <= rev_d;
`endif
        end
    end
endmodule

// File: tb/tb_matrix_c_row_streamer.sv
// Directed and randomized bench for matrix_c_row_streamer against a
// transfer-list reference model.
module tb_matrix_c_row_streamer;
    localparam int DW   = 160;
    localparam int N    = 5;
    localparam int IDXW = 3;
    localparam int RW   = 3;

    typedef logic [DW-1:0] row_t;
    typedef struct {
        row_t d;
        int   idx;
        bit   last;
    } xfer_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    row_t          in [N];
    logic [RW-1:0] active_rows;
    logic          busy, done, load_err;
`ifdef MATRIX_C_ROW_STREAMER_REVERSE_EN
    logic          reverse;
`endif

    matrix_c_row_streamer_if #(.DATAWIDTH(DW), .IDXW(IDXW)) o_if ();

    matrix_c_row_streamer #(.DATAWIDTH(DW), .N_SIZE(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .in          (in),
        .active_rows (active_rows),
`ifdef MATRIX_C_ROW_STREAMER_REVERSE_EN
        .reverse     (reverse),
`endif
        .o           (o_if.master),
        .busy        (busy),
        .done        (done),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    xfer_t q[$];
    bit    exp_done = 0;
    bit    exp_err  = 0;
    row_t  mat [N];
    bit    rev_in = 0;

    function automatic row_t rnd_row();
        row_t r = '0;
        for (int i = 0; i < 5; i++) r = (r << 32) | row_t'($urandom);
        return r;
    endfunction

    task automatic chk(string tag, row_t obs, row_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_valid"}, row_t'(o_if.out_valid), '0);
        chk({tag, "_data"}, o_if.out_data, '0);
        chk({tag, "_idx"}, row_t'(o_if.out_row_idx), '0);
        chk({tag, "_last"}, row_t'(o_if.out_last), '0);
        chk({tag, "_busy"}, row_t'(busy), '0);
        chk({tag, "_done"}, row_t'(done), '0);
        chk({tag, "_err"}, row_t'(load_err), '0);
    endtask

    // One clock: drive inputs, compare outputs to the model, update the model.
    task automatic cycle(input bit ld, input bit rdy, input int ar);
        bit v, fl, acc;
        int eff;
        load        = ld;
        o_if.out_ready = rdy;
        active_rows = RW'(ar);
`ifdef MATRIX_C_ROW_STREAMER_REVERSE_EN
        reverse     = rev_in;
`endif
        for (int i = 0; i < N; i++) in[i] = ld ? mat[i] : rnd_row();
        v = (q.size() != 0);
        chk("valid", row_t'(o_if.out_valid), row_t'(v));
        chk("busy", row_t'(busy), row_t'(v));
        chk("data", o_if.out_data, v ? q[0].d : '0);
        chk("last", row_t'(o_if.out_last), row_t'(v && q[0].last));
        if (v) chk("idx", row_t'(o_if.out_row_idx), row_t'(q[0].idx));
        chk("done", row_t'(done), row_t'(exp_done));
        chk("load_err", row_t'(load_err), row_t'(exp_err));
        fl  = v && rdy && q[0].last;
        acc = ld && (!v || fl);
        if (v && rdy) void'(q.pop_front());
        exp_done = fl;
        exp_err  = ld && !acc;
        if (acc) begin
            eff = (ar == 0 || ar > N) ? N : ar;
            for (int k = 0; k < eff; k++) begin
                int r;
                r = rev_in ? eff - 1 - k : k;
                q.push_back('{d: mat[r], idx: r, last: (k == eff - 1)});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic seq_mat(input int base);
        for (int i = 0; i < N; i++) mat[i] = row_t'(base + i);
    endtask

    task automatic drain();
        repeat (8) cycle(1'b0, 1'b1, 5);
    endtask

    initial begin
        rst_n = 1'b0;
        load = 1'b0;
        active_rows = '0;
        o_if.out_ready = 1'b0;
`ifdef MATRIX_C_ROW_STREAMER_REVERSE_EN
        reverse = 1'b0;
`endif
        for (int i = 0; i < N; i++) in[i] = '0;
        #3;
        chk_zero("reset");
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic stream, rows 1..5
        seq_mat(1);
        cycle(1'b1, 1'b1, 5);
        repeat (7) cycle(1'b0, 1'b1, 5);

        // Backpressure 1,0,0,1,...
        seq_mat(1);
        cycle(1'b1, 1'b1, 5);
        for (int i = 0; i < 16; i++) cycle(1'b0, (i % 3) == 0, 5);
        drain();

        // Active-row clamping
        seq_mat(1);
        cycle(1'b1, 1'b1, 3);
        drain();
        cycle(1'b1, 1'b1, 0);
        drain();
        cycle(1'b1, 1'b1, 7);
        drain();

        // Rejected load at idx 1 must not disturb the buffer
        seq_mat(1);
        cycle(1'b1, 1'b1, 5);
        cycle(1'b0, 1'b1, 5);
        for (int i = 0; i < N; i++) mat[i] = rnd_row();
        cycle(1'b1, 1'b0, 5);
        drain();

        // Back-to-back load on the final handshake
        seq_mat(1);
        cycle(1'b1, 1'b1, 5);
        repeat (4) cycle(1'b0, 1'b1, 5);
        seq_mat(10);
        cycle(1'b1, 1'b1, 5);
        drain();

        // Reset mid-stream at idx 2
        seq_mat(1);
        cycle(1'b1, 1'b1, 5);
        repeat (2) cycle(1'b0, 1'b1, 5);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        q.delete();
        exp_done = 0;
        exp_err  = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b0, 1'b1, 5);
        seq_mat(20);
        cycle(1'b1, 1'b1, 5);
        drain();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit ld;
            ld = ($urandom % 5) == 0;
            if (ld) for (int r = 0; r < N; r++) mat[r] = rnd_row();
`ifdef MATRIX_C_ROW_STREAMER_REVERSE_EN
            if (ld) rev_in = $urandom % 2;
`endif
            cycle(ld, ($urandom % 4) != 0, int'($urandom % 8));
        end
        rev_in = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
